// File: rtl/tx_slot_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tx_slot_writer
//  Purpose  : Write-side controller of the TX frame slot RAM ring. Takes a
//             16-bit word stream (len, timestamp, hash, payload), checks the
//             ring has room ahead of the sender's read pointer, writes the
//             frame into the ring and only then publishes it by moving
//             mem_wr_ptr. Malformed or aborted frames are dropped unpublished.
//  Revision : 1.0  initial release
// ============================================================================
module tx_slot_writer #(
    parameter int PTR_W   = 16,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1518
) (
    input  logic             gmii_tx_clk,
    input  logic             sys_rst,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_abort,
    output logic             in_ready,
    output logic [PTR_W-1:0] ram_addr,
    output logic [15:0]      ram_data,
    output logic [1:0]       ram_byte_en,
    output logic             ram_wr_en,
    input  logic [PTR_W-1:0] mem_rd_ptr,
    output logic [PTR_W-1:0] mem_wr_ptr,
    output logic [31:0]      frames_committed,
    output logic [31:0]      frames_dropped,
    output logic             busy
);

    localparam logic [PTR_W-1:0] c_ONE = PTR_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DROP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_len;
    logic             r_len_last;
    logic [PTR_W-1:0] r_base;
    logic [PTR_W-1:0] r_cnt;
    logic             r_in_ready;
    logic [PTR_W-1:0] r_ram_addr;
    logic [15:0]      r_ram_data;
    logic             r_ram_wr_en;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [31:0]      r_committed;
    logic [31:0]      r_dropped;

    logic             w_accept;
    logic [31:0]      w_need;
    logic [PTR_W-1:0] w_free_p;
    logic [31:0]      w_free;
    logic             w_len_ok;
    logic             w_fits;
    logic             w_at_end;

    logic             w_wr;
    logic [PTR_W-1:0] w_wr_addr;
    logic [15:0]      w_wr_data;
    logic             w_latch_len;
    logic             w_cnt_init;
    logic             w_cnt_inc;
    logic             w_drop;
    logic             w_commit;
    logic             w_ready_nxt;

    // Frame size and ring room are compared in 32 bits so a long length can
    // never alias into a small value when PTR_W is narrow.
    assign w_accept = in_valid & r_in_ready;
    assign w_need   = 32'd7 + ((32'(r_len) + 32'd1) >> 1);
    assign w_free_p = mem_rd_ptr - r_wr_ptr - c_ONE;
    assign w_free   = 32'(w_free_p);
    assign w_len_ok = (r_len >= 16'(MIN_LEN)) && (r_len <= 16'(MAX_LEN));
    assign w_fits   = (w_need <= w_free);
    assign w_at_end = (32'(r_cnt) == (w_need - 32'd1));

    // State register
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath controls; abort outranks last
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wr_addr   = r_base;
        w_wr_data   = in_data;
        w_latch_len = 1'b0;
        w_cnt_init  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_drop      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_latch_len = 1'b1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (in_abort) begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!w_len_ok) begin
                    w_drop      = 1'b1;
                    w_state_nxt = r_len_last ? ST_IDLE : ST_DROP;
                end else if (w_fits) begin
                    // Length word lands at the frame base once room is known
                    w_wr        = 1'b1;
                    w_wr_addr   = r_base;
                    w_wr_data   = r_len;
                    w_cnt_init  = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (in_abort) begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_wr      = 1'b1;
                    w_wr_addr = r_base + r_cnt;
                    w_wr_data = in_data;
                    w_cnt_inc = 1'b1;
                    if (w_at_end) begin
                        if (in_last) begin
                            w_state_nxt = ST_COMMIT;
                        end else begin
                            w_drop      = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end else if (in_last) begin
                        w_drop      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                if (w_accept && in_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // in_ready is registered from the next state so it reads 0 while in reset
    assign w_ready_nxt = (w_state_nxt == ST_IDLE) ||
                         (w_state_nxt == ST_WRITE) ||
                         (w_state_nxt == ST_DROP);

    // Datapath: frame context, registered RAM port, published pointer, counters
    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_len       <= '0;
            r_len_last  <= 1'b0;
            r_base      <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_wr_en <= 1'b0;
            r_wr_ptr    <= '0;
            r_committed <= '0;
            r_dropped   <= '0;
        end else begin
            r_in_ready  <= w_ready_nxt;
            r_ram_wr_en <= w_wr;
            if (w_wr) begin
                r_ram_addr <= w_wr_addr;
                r_ram_data <= w_wr_data;
            end
            if (w_latch_len) begin
                r_len      <= in_data;
                r_len_last <= in_last;
                r_base     <= r_wr_ptr;
            end
            if (w_cnt_init) begin
                r_cnt <= c_ONE;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_ONE;
            end
            if (w_commit) begin
                r_wr_ptr    <= r_base + w_need[PTR_W-1:0];
                r_committed <= r_committed + 32'd1;
            end
            if (w_drop) begin
                r_dropped <= r_dropped + 32'd1;
            end
        end
    end

    assign in_ready         = r_in_ready;
    assign ram_addr         = r_ram_addr;
    assign ram_data         = r_ram_data;
    assign ram_wr_en        = r_ram_wr_en;
    assign ram_byte_en      = r_ram_wr_en ? 2'b11 : 2'b00;
    assign mem_wr_ptr       = r_wr_ptr;
    assign frames_committed = r_committed;
    assign frames_dropped   = r_dropped;
    assign busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_slot_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_slot_writer
//  Purpose  : Self-checking bench for tx_slot_writer. Frames are described at
//             the word-list level; expected RAM contents, published pointer
//             and counters come from a frame-level model of the ring.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tx_slot_writer;

    localparam int MASK   = 65535;
    localparam int K_GOOD = 0;
    localparam int K_BAD  = 1;
    localparam int K_EARLY = 2;
    localparam int K_OVER = 3;
    localparam int K_ABORT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_abort;
    logic        in_ready;
    logic [15:0] ram_addr;
    logic [15:0] ram_data;
    logic [1:0]  ram_byte_en;
    logic        ram_wr_en;
    logic [15:0] mem_rd_ptr;
    logic [15:0] mem_wr_ptr;
    logic [31:0] frames_committed;
    logic [31:0] frames_dropped;
    logic        busy;

    always #5 clk = ~clk;

    tx_slot_writer #(.PTR_W(16), .MIN_LEN(60), .MAX_LEN(1518)) u_dut (
        .gmii_tx_clk      (clk),
        .sys_rst          (rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_abort         (in_abort),
        .in_ready         (in_ready),
        .ram_addr         (ram_addr),
        .ram_data         (ram_data),
        .ram_byte_en      (ram_byte_en),
        .ram_wr_en        (ram_wr_en),
        .mem_rd_ptr       (mem_rd_ptr),
        .mem_wr_ptr       (mem_wr_ptr),
        .frames_committed (frames_committed),
        .frames_dropped   (frames_dropped),
        .busy             (busy)
    );

    int total = 0;
    int bad   = 0;

    // Frame-level model of the ring
    int model_wr = 0;
    int mc = 0;
    int md = 0;
    int frame_id = 0;
    int nwr0 = 0;
    logic [15:0] fw [0:1023];

    // Observed RAM image, written only by the monitor
    logic [15:0] shadow [0:65535];
    int          stamp  [0:65535];
    int          nwr = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          ptr_chg_cyc = 0;
    int          be_err = 0;
    logic [15:0] prev_ptr = '0;

    // Monitor: record every RAM write and every movement of mem_wr_ptr
    always @(negedge clk) begin
        if (rst) begin
            prev_ptr = '0;
        end else begin
            cyc++;
            if (ram_wr_en === 1'b1) begin
                shadow[ram_addr] = ram_data;
                stamp[ram_addr]  = frame_id;
                nwr++;
                last_wr_cyc = cyc;
                if (ram_byte_en !== 2'b11) be_err++;
            end else if (ram_byte_en !== 2'b00) begin
                be_err++;
            end
            if (mem_wr_ptr !== prev_ptr) begin
                ptr_chg_cyc = cyc;
                prev_ptr    = mem_wr_ptr;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic build_words(input int len);
        fw[0] = 16'(len);
        for (int i = 1; i < 1024; i++) fw[i] = 16'($urandom);
    endtask

    // Present one word and hold it until the handshake completes
    task automatic drive_word(input logic [15:0] d, input bit last);
        int t = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int base, input int nexp, input bit good);
        int mism = 0;
        int a;
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, 64'(nwr - nwr0), 64'(nexp));
        for (int i = 0; i < nexp; i++) begin
            a = (base + i) & MASK;
            if (shadow[a] !== fw[i] || stamp[a] != frame_id) mism++;
        end
        chk({tag, "_data"}, 64'(mism), 64'd0);
        chk({tag, "_wrptr"}, 64'(mem_wr_ptr), 64'(model_wr));
        chk({tag, "_committed"}, 64'(frames_committed), 64'(mc));
        chk({tag, "_dropped"}, 64'(frames_dropped), 64'(md));
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        if (good) chk({tag, "_pub_lat"}, 64'(ptr_chg_cyc - last_wr_cyc), 64'd1);
    endtask

    // Send one frame of the given shape and check it against the model
    task automatic do_frame(input string tag, input int len, input int kind, input int k);
        int need;
        int base;
        int nexp = 0;
        bit good = 1'b0;
        need = 7 + (len + 1) / 2;
        base = model_wr;
        build_words(len);
        frame_id++;
        nwr0 = nwr;
        case (kind)
            K_GOOD: begin
                for (int i = 0; i < need; i++) begin
                    in_abort = (k == 1 && i == 0);
                    drive_word(fw[i], (i == need - 1));
                    in_abort = 1'b0;
                end
                nexp = need;
                good = 1'b1;
            end
            K_BAD: begin
                for (int i = 0; i < k; i++) begin
                    in_abort = (k >= 3 && i == k - 1);
                    drive_word(fw[i], (i == k - 1));
                    in_abort = 1'b0;
                end
                nexp = 0;
            end
            K_EARLY: begin
                for (int i = 0; i <= k; i++) drive_word(fw[i], (i == k));
                nexp = k + 1;
            end
            K_OVER: begin
                for (int i = 0; i < need; i++) drive_word(fw[i], 1'b0);
                drive_word(16'($urandom), 1'b1);
                nexp = need;
            end
            default: begin
                for (int i = 0; i < k; i++) drive_word(fw[i], 1'b0);
                in_abort = 1'b1;
                in_valid = 1'b1;
                in_data  = fw[k];
                in_last  = 1'b1;
                @(negedge clk);
                in_abort = 1'b0;
                in_valid = 1'b0;
                in_last  = 1'b0;
                nexp = (k == 1) ? 0 : k;
            end
        endcase
        if (good) begin
            model_wr = (model_wr + need) & MASK;
            mc++;
        end else begin
            md++;
        end
        check_frame(tag, base, nexp, good);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int len;
        int need;
        int r;
        int n;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_abort   = 1'b0;
        mem_rd_ptr = '0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
        chk("rst_byte_en", {62'd0, ram_byte_en}, 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_data", 64'(ram_data), 64'd0);
        chk("rst_wrptr", 64'(mem_wr_ptr), 64'd0);
        chk("rst_committed", 64'(frames_committed), 64'd0);
        chk("rst_dropped", 64'(frames_dropped), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ready", {63'd0, in_ready}, 64'd1);

        // Directed frames
        do_frame("t1_len60", 60, K_GOOD, 0);
        chk("t1_ptr37", 64'(mem_wr_ptr), 64'd37);
        do_frame("t2_len61_over", 61, K_OVER, 0);
        chk("t2_drop1", 64'(frames_dropped), 64'd1);
        chk("t2_ptr37", 64'(mem_wr_ptr), 64'd37);
        do_frame("t3_len20", 20, K_BAD, 3);
        do_frame("t4_abort_w10", 60, K_ABORT, 9);
        do_frame("t4_same_base", 60, K_GOOD, 0);
        chk("t4_ptr", 64'(mem_wr_ptr), 64'd74);
        do_frame("t5_len1519_last", 1519, K_BAD, 1);
        do_frame("t5_len59", 59, K_BAD, 2);
        do_frame("t5_len1518", 1518, K_GOOD, 0);
        do_frame("t5_early", 100, K_EARLY, 5);
        do_frame("t5_abort_check", 60, K_ABORT, 1);

        // Random frames with plenty of ring room
        repeat (40) begin
            kind = $urandom_range(0, 4);
            len  = $urandom_range(60, 1518);
            need = 7 + (len + 1) / 2;
            mem_rd_ptr = 16'((model_wr + 40000) & MASK);
            case (kind)
                K_GOOD:  do_frame("rnd_good", len, K_GOOD, $urandom_range(0, 1));
                K_BAD:   do_frame("rnd_bad",
                                  ($urandom_range(0, 1) == 1) ? $urandom_range(0, 59)
                                                              : $urandom_range(1519, 65535),
                                  K_BAD, $urandom_range(1, 4));
                K_EARLY: do_frame("rnd_early", len, K_EARLY, $urandom_range(1, need - 2));
                K_OVER:  do_frame("rnd_over", len, K_OVER, 0);
                default: do_frame("rnd_abort", len, K_ABORT, $urandom_range(1, need - 1));
            endcase
        end

        // Fill the ring up to 65500 with legal frames
        while (model_wr != 65500) begin
            r = 65500 - model_wr;
            if (r >= 803) n = 766;
            else if (r > 766) n = r - 37;
            else n = r;
            mem_rd_ptr = 16'((model_wr + 40000) & MASK);
            do_frame("fill", 2 * (n - 7), K_GOOD, 0);
        end
        chk("fill_ptr", 64'(mem_wr_ptr), 64'd65500);

        // Not enough room (free=35, need=37): stall in CHECK, then release
        mem_rd_ptr = 16'd0;
        build_words(60);
        frame_id++;
        nwr0 = nwr;
        drive_word(fw[0], 1'b0);
        repeat (8) @(negedge clk);
        chk("stall_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_busy", {63'd0, busy}, 64'd1);
        chk("stall_nowrite", 64'(nwr - nwr0), 64'd0);
        mem_rd_ptr = 16'd2;
        for (int i = 1; i < 37; i++) drive_word(fw[i], (i == 36));
        model_wr = (65500 + 37) & MASK;
        mc++;
        check_frame("wrap", 65500, 37, 1'b1);
        chk("wrap_ptr1", 64'(mem_wr_ptr), 64'd1);
        chk("wrap_last_addr", 64'(shadow[0]), 64'(fw[36]));

        // Reset in the middle of WRITE
        mem_rd_ptr = 16'd0;
        build_words(60);
        frame_id++;
        for (int i = 0; i < 11; i++) drive_word(fw[i], 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", {63'd0, ram_wr_en}, 64'd0);
        chk("mid_rst_byte_en", {62'd0, ram_byte_en}, 64'd0);
        chk("mid_rst_addr", 64'(ram_addr), 64'd0);
        chk("mid_rst_wrptr", 64'(mem_wr_ptr), 64'd0);
        chk("mid_rst_committed", 64'(frames_committed), 64'd0);
        chk("mid_rst_dropped", 64'(frames_dropped), 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_wr = 0;
        mc = 0;
        md = 0;
        do_frame("restart", 60, K_GOOD, 0);
        chk("restart_ptr37", 64'(mem_wr_ptr), 64'd37);

        chk("byte_en_rule", 64'(be_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
